bcd_digit_sequencer: RTL and testbench

- Time-shares one external combinational 4-bit digit code converter across a DIGITS-nibble BCD word.
- Captures a packed word on a valid/ready handshake and presents one nibble per cycle on conv_in, least significant first.
- Samples conv_out in the same cycle, reassembles the converted word and returns it on a valid/ready output handshake.
- Sits between the digit-entry/register logic and the display/encode path.

---
 rtl/bcd_digit_sequencer_if.sv | 25 ++
 rtl/bcd_digit_sequencer.sv | 105 ++++++++++
 tb/tb_bcd_digit_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_sequencer_if.sv
// Handshake and converter bus for bcd_digit_sequencer.
// The slave modport is the sequencer side. The master modport is the producer/consumer/converter side.
interface bcd_digit_sequencer_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_data;
    logic [3:0]            conv_in;
    logic [3:0]            conv_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic                  out_err;

    modport slave (
        input  in_valid, in_data, conv_out, out_ready,
        output in_ready, conv_in, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_data, conv_out, out_ready,
        input  in_ready, conv_in, out_valid, out_data, out_err
    );
endinterface

// File: rtl/bcd_digit_sequencer.sv
// Time-shares one combinational nibble converter across a DIGITS-nibble word, LSB first.
// Optional range check (nibble > 9 -> 4'hF and sticky error) is enabled by defining BCD_SEQ_ERRCHK_EN.
module bcd_digit_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_digit_sequencer_if.slave  bus,
    output logic                  busy
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0][3:0] buf_q, buf_d;
    logic [DIGITS-1:0][3:0] res_q, res_d;
    logic                   accept, last;
    logic [3:0]             cur_nib, res_nib;

    assign accept  = (state_q == S_IDLE) && bus.in_valid;
    assign last    = (idx_q == LAST);
    assign cur_nib = buf_q[idx_q];

`ifdef BCD_SEQ_ERRCHK_EN
    logic err_q, err_d, nib_bad;

    // The converter result is discarded for out-of-range digits.
    assign nib_bad = (cur_nib > 4'd9);
    assign res_nib = nib_bad ? 4'hF : bus.conv_out;

    always_comb begin
        err_d = err_q;
        if (accept)
            err_d = 1'b0;
        else if (state_q == S_CONV)
            err_d = err_q | nib_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.out_err = err_q && (state_q == S_DONE);
`else
    assign res_nib     = bus.conv_out;
    assign bus.out_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_CONV;
            S_CONV:  if (last)         state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state only.
    // conv_in therefore has no combinational path from in_data or out_ready.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        bus.conv_in   = (state_q == S_CONV) ? cur_nib : 4'h0;
        bus.out_data  = res_q;
    end

    always_comb begin
        idx_d = idx_q;
        buf_d = buf_q;
        res_d = res_q;
        if (accept) begin
            buf_d = bus.in_data;
            res_d = '0;
            idx_d = '0;
        end else if (state_q == S_CONV) begin
            res_d[idx_q] = res_nib;
            if (!last) idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            buf_q <= '0;
            res_q <= '0;
        end else begin
            idx_q <= idx_d;
            buf_q <= buf_d;
            res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Self-checking bench for bcd_digit_sequencer with an excess-3 converter stub.
// A cycle-count transaction model is checked every cycle; directed literals pin that model.
module tb_bcd_digit_sequencer;
    localparam int D = 4;
    localparam int W = 4 * D;
`ifdef BCD_SEQ_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_digit_sequencer_if #(.DIGITS(D)) bus();
    assign bus.conv_out = bus.conv_in + 4'd3;

    bcd_digit_sequencer #(.DIGITS(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int k = 0; k < D; k++) begin
            if (ERRCHK && w[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'hF;
            else                              r[4*k +: 4] = w[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic exp_err(input logic [W-1:0] w);
        logic e = 1'b0;
        for (int k = 0; k < D; k++) if (w[4*k +: 4] > 4'd9) e = 1'b1;
        return ERRCHK && e;
    endfunction

    // Model: mph = -1 idle, 0..D-1 cycles spent converting digit mph, D = result waiting.
    int           mph = -1;
    logic [W-1:0] mword = '0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst)                   mph = -1;
        else if (mph == -1) begin
            if (bus.in_valid) begin mword = bus.in_data; mph = 0; end
        end else if (mph < D)      mph = mph + 1;
        else if (bus.out_ready)    mph = -1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready",  bus.in_ready,  mph == -1);
            chk("m_out_valid", bus.out_valid, mph == D);
            chk("m_busy",      busy,          mph != -1);
            chk("m_conv_in",   bus.conv_in,   (mph >= 0 && mph < D) ? mword[4*mph +: 4] : 4'h0);
            if (mph == D) begin
                chk("m_out_data", bus.out_data, exp_word(mword));
                chk("m_out_err",  bus.out_err,  exp_err(mword));
            end else begin
                chk("m_out_err_idle", bus.out_err, 1'b0);
            end
        end
    end

    logic [W-1:0] obs_q[$];
    always @(posedge clk)
        if (!rst && bus.out_valid && bus.out_ready) obs_q.push_back(bus.out_data);

    task automatic wait_acc(output time t);
        bit got = 1'b0;
        t = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            if (bus.in_ready && bus.in_valid) begin got = 1'b1; t = $time; end
            #1;
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [W-1:0] w, output time t);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        wait_acc(t);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [W-1:0] d, output logic e, output time t);
        bit got = 1'b0;
        d = '0; e = 1'b0; t = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got = 1'b1; d = bus.out_data; e = bus.out_err; t = $time;
            end
            #1;
        end
        if (!got) chk("output_timeout", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        time          ta, tb2, tt;
        logic [W-1:0] d;
        logic         e;
        logic [15:0]  seq;
        bit           seen;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data",  bus.out_data,  16'h0000);
        chk("rst_out_err",   bus.out_err,   1'b0);
        chk("rst_busy",      busy,          1'b0);
        chk("rst_conv_in",   bus.conv_in,   4'h0);
        chk_en = 1'b1;

        // Basic
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(16'h1234, ta);
        seq = '0;
        for (int k = 0; k < D; k++) begin
            @(negedge clk);
            seq = {seq[11:0], bus.conv_in};
        end
        chk("basic_conv_seq", seq, 16'h4321);
        @(negedge clk);
        chk("basic_valid_after_4", bus.out_valid, 1'b1);
        chk("basic_data", bus.out_data, 16'h4567);
        chk("basic_err",  bus.out_err,  1'b0);
        wait_out(d, e, tt);
        chk("basic_xfer_time", 32'(tt - ta), 32'd50);

        // Backpressure, with an ignored in_valid while busy
        bus.out_ready = 1'b0;
        send(16'h0909, ta);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        chk("bp_valid_seen", seen, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.in_valid = (i < 5);
            bus.in_data  = 16'h1111;
            @(negedge clk);
            chk("bp_hold_data",  bus.out_data,  16'h3C3C);
            chk("bp_hold_ready", bus.in_ready,  1'b0);
            chk("bp_hold_valid", bus.out_valid, 1'b1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_out(d, e, tt);
        chk("bp_data", d, 16'h3C3C);
        @(negedge clk);
        chk("bp_ready_after", bus.in_ready, 1'b1);

        // Back-to-back with in_valid held
        obs_q.delete();
        @(posedge clk); #1;
        bus.in_data = 16'h0000; bus.in_valid = 1'b1;
        wait_acc(ta);
        bus.in_data = 16'h9999;
        wait_acc(tb2);
        bus.in_valid = 1'b0;
        chk("b2b_interval", 32'(tb2 - ta), 32'd60);
        for (int i = 0; i < 30 && obs_q.size() < 2; i++) @(posedge clk);
        #1;
        chk("b2b_count", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            chk("b2b_first",  obs_q[0], 16'h3333);
            chk("b2b_second", obs_q[1], 16'hCCCC);
        end

        // Reset in the second CONV cycle
        obs_q.delete();
        send(16'h5678, ta);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready",  bus.in_ready,  1'b1);
        chk("mrst_out_valid", bus.out_valid, 1'b0);
        chk("mrst_out_data",  bus.out_data,  16'h0000);
        repeat (12) @(negedge clk);
        chk("mrst_no_output", obs_q.size(), 0);

        // Out-of-range digit
        @(posedge clk); #1;
        send(16'h12A4, ta);
        wait_out(d, e, tt);
        chk("err_data", d, ERRCHK ? 16'h45F7 : 16'h45D7);
        chk("err_flag", e, ERRCHK);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 79) == 0);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = ($urandom_range(0, 3) == 0) ? W'($urandom)
                          : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            bus.out_ready = $urandom_range(0, 1);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
